// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage in front of the icache.
// Keeps the PC and issues one word-aligned read at a time.
// Returned words go, with their PC and a fault flag, into a small FIFO
// that feeds decode. A redirect flushes the FIFO and drops the one
// response that may still be outstanding.
// Optional feature: define IFU_PERF_EN to add saturating perf counters
// (perf_fetch_cnt, perf_discard_cnt, perf_stall_cnt).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  output logic [31:0] ic_araddr,
  output logic        ic_arvalid,
  input  logic        ic_arready,
  input  logic [31:0] ic_rdata,
  input  logic [1:0]  ic_rresp,
  input  logic        ic_rvalid,
  output logic        ic_rready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int          AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic          discard;
  logic          halted;

  logic [31:0]   mem_pc    [BUF_DEPTH];
  logic [31:0]   mem_inst  [BUF_DEPTH];
  logic          mem_fault [BUF_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          ar_fire;
  logic          r_fire;
  logic          issue;
  logic          push;
  logic          pop;
  logic          resp_fault;
  logic          unused_ok;

  // Low address bits of the redirect target are forced to zero.
  assign unused_ok  = ^redirect_pc[1:0];

  assign ic_arvalid = (state == S_REQ);
  assign ic_rready  = (state == S_RESP);
  assign ar_fire    = ic_arvalid && ic_arready;
  assign r_fire     = ic_rvalid && ic_rready;
  assign resp_fault = (ic_rresp != 2'b00);

  // Nothing is in flight while idle, so the slot check reduces to the FIFO
  // count; the slot reserved here is what lets rready stay high in RESP.
  assign issue = (state == S_IDLE) && !halted && (count < DEPTH) && !redirect_valid;

  // Redirect wins over both FIFO ports in the same cycle.
  assign push = r_fire && !discard && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  // Request FSM; the address is latched at issue and held through the handshake.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state     <= S_IDLE;
      ic_araddr <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: if (issue) begin
          state     <= S_REQ;
          ic_araddr <= pc;
        end
        S_REQ:   if (ar_fire) state <= S_RESP;
        S_RESP:  if (r_fire)  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // PC, halt-on-fault and stale-response tracking.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      pc      <= RESET_PC;
      discard <= 1'b0;
      halted  <= 1'b0;
    end else if (redirect_valid) begin
      pc      <= {redirect_pc[31:2], 2'b00};
      halted  <= 1'b0;
      // Only a transaction still open after this edge needs dropping; one that
      // completes in the redirect cycle is already discarded by the push gate.
      discard <= (state == S_REQ) || ((state == S_RESP) && !ic_rvalid);
    end else if (r_fire) begin
      if (discard) begin
        discard <= 1'b0;
      end else if (resp_fault) begin
        halted  <= 1'b1;
      end else begin
        pc      <= pc + 32'd4;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties it outright.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO storage; contents are only observed through the valid-gated outputs.
  always_ff @(posedge M_AXI_ACLK) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_inst[wr_ptr]  <= ic_rdata;
      mem_fault[wr_ptr] <= resp_fault;
    end
  end

  // Head of FIFO, zeroed when empty so reset drops outputs without a clock.
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? mem_pc[rd_ptr]    : 32'd0;
  assign out_inst  = out_valid ? mem_inst[rd_ptr]  : 32'd0;
  assign out_fault = out_valid ? mem_fault[rd_ptr] : 1'b0;

`ifdef IFU_PERF_EN
  // Saturating event counters.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      perf_fetch_cnt   <= '0;
      perf_discard_cnt <= '0;
      perf_stall_cnt   <= '0;
    end else begin
      if (push && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (r_fire && !push && (perf_discard_cnt != '1))
        perf_discard_cnt <= perf_discard_cnt + 32'd1;
      if (out_ready && !out_valid && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_ifu_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ic_araddr;
  logic        ic_arvalid;
  logic        ic_arready = 1'b0;
  logic [31:0] ic_rdata = 32'd0;
  logic [1:0]  ic_rresp = 2'b00;
  logic        ic_rvalid = 1'b0;
  logic        ic_rready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_discard_cnt, perf_stall_cnt;
`endif

  ifu_fetch #(.RESET_PC(32'h8000_0000), .BUF_DEPTH(DEPTH)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .ic_araddr(ic_araddr), .ic_arvalid(ic_arvalid), .ic_arready(ic_arready),
    .ic_rdata(ic_rdata), .ic_rresp(ic_rresp), .ic_rvalid(ic_rvalid), .ic_rready(ic_rready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_fault(out_fault)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_discard_cnt(perf_discard_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // icache stand-in controls
  bit          ar_block = 1'b0;
  bit          r_block = 1'b0;
  bit          fault_en = 1'b0;
  bit          data_fixed = 1'b1;
  logic [31:0] fault_addr = 32'd0;
  logic [31:0] resp_addr = 32'd0;

  // observation logs
  logic [31:0] hs_q[$];
  logic [31:0] pop_q[$];
  logic [31:0] popi_q[$];
  logic        popf_q[$];

  // model state
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } ent_t;
  ent_t        mq[$];
  int          m_phase;   // 0 nothing open, 1 address pending, 2 data pending
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_discard;
  bit          m_halted;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // icache: accepts whenever not blocked, answers in the cycle after the handshake
  always @(posedge clk) begin
    #2;
    ic_arready = !ar_block;
    ic_rvalid  = ic_rready && !r_block;
    ic_rdata   = data_fixed ? 32'h0000_0013 : (resp_addr ^ 32'h5A5A_0003);
    ic_rresp   = (fault_en && resp_addr == fault_addr) ? 2'b10 : 2'b00;
  end

  // log, compare against model, then advance model by this cycle's inputs
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_phase = 0; m_pc = 32'h8000_0000; m_addr = 32'h8000_0000;
      m_discard = 1'b0; m_halted = 1'b0;
    end else begin
      bit issue, redir, rv;
      int sz;
      if (ic_arvalid && ic_arready) begin hs_q.push_back(ic_araddr); resp_addr = ic_araddr; end
      if (out_valid && out_ready) begin
        pop_q.push_back(out_pc); popi_q.push_back(out_inst); popf_q.push_back(out_fault);
      end

      chk("arvalid", 32'(ic_arvalid), 32'(m_phase == 1));
      chk("rready", 32'(ic_rready), 32'(m_phase == 2));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (m_phase == 1) chk("araddr", ic_araddr, m_addr);
      if (mq.size() > 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_inst", out_inst, mq[0].inst);
        chk("out_fault", 32'(out_fault), 32'(mq[0].fault));
      end

      sz    = mq.size();
      redir = redirect_valid;
      rv    = (m_phase == 2) && ic_rvalid;
      issue = (m_phase == 0) && !m_halted && (sz < DEPTH) && !redir;
      if (redir) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        m_halted = 1'b0;
        // still owed a response after this edge?
        m_discard = (m_phase == 1) || (m_phase == 2 && !ic_rvalid);
      end else begin
        if (out_ready && sz > 0) void'(mq.pop_front());
        if (rv) begin
          if (m_discard) m_discard = 1'b0;
          else begin
            mq.push_back('{pc: m_pc, inst: ic_rdata, fault: (ic_rresp != 2'b00)});
            if (ic_rresp != 2'b00) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
          end
        end
      end
      case (m_phase)
        0: if (issue) begin m_phase = 1; m_addr = m_pc; end
        1: if (ic_arready) m_phase = 2;
        default: if (ic_rvalid) m_phase = 0;
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_q.delete(); pop_q.delete(); popi_q.delete(); popf_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_for(input int which, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      case (which)
        0: hit = ic_arvalid;
        1: hit = ic_rready;
        default: hit = out_valid;
      endcase
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL wait_%s: got 0 want 1 within 40 cycles", nm);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_arvalid", 32'(ic_arvalid), 32'd0);
    chk("rst_araddr", ic_araddr, 32'h8000_0000);
    chk("rst_rready", 32'(ic_rready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);

    // 1: streaming with one-cycle icache
    do_reset();
    cyc(14);
    chk("t1_addr0", hs_q[0], 32'h8000_0000);
    chk("t1_addr1", hs_q[1], 32'h8000_0004);
    chk("t1_addr2", hs_q[2], 32'h8000_0008);
    chk("t1_pc0", pop_q[0], 32'h8000_0000);
    chk("t1_pc1", pop_q[1], 32'h8000_0004);
    chk("t1_pc2", pop_q[2], 32'h8000_0008);
    chk("t1_inst2", popi_q[2], 32'h0000_0013);

    // 2: decode stalled, buffer fills, then one pop frees one slot
    out_ready = 1'b0;
    do_reset();
    cyc(15);
    chk("t2_nreq", 32'(hs_q.size()), 32'd2);
    chk("t2_addr1", hs_q[1], 32'h8000_0004);
    chk("t2_idle", 32'(ic_arvalid), 32'd0);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(10);
    chk("t2_nreq_after", 32'(hs_q.size()), 32'd3);
    chk("t2_addr2", hs_q[2], 32'h8000_0008);
    chk("t2_npop", 32'(pop_q.size()), 32'd1);

    // 3: redirect during RESP, misaligned target
    data_fixed = 1'b0; out_ready = 1'b1; r_block = 1'b1;
    do_reset();
    wait_for(1, "t3_rready");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    r_block = 1'b0;
    cyc(12);
    chk("t3_addr0", hs_q[0], 32'h8000_0000);
    chk("t3_addr1", hs_q[1], 32'h8000_1000);
    chk("t3_pc0", pop_q[0], 32'h8000_1000);
    chk("t3_inst0", popi_q[0], 32'hDA5A_1003);

    // 4: redirect while the address handshake is stalled
    ar_block = 1'b1;
    do_reset();
    wait_for(0, "t4_arvalid");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    for (int i = 0; i < 3; i++) begin
      chk("t4_araddr_hold", ic_araddr, 32'h8000_0000);
      chk("t4_arvalid_hold", 32'(ic_arvalid), 32'd1);
      cyc(1);
      redirect_valid = 1'b0;
    end
    ar_block = 1'b0;
    cyc(12);
    chk("t4_addr0", hs_q[0], 32'h8000_0000);
    chk("t4_addr1", hs_q[1], 32'h8000_0200);
    chk("t4_pc0", pop_q[0], 32'h8000_0200);

    // 5: bus error halts fetch until redirect
    data_fixed = 1'b1; fault_en = 1'b1; fault_addr = 32'h8000_0004;
    do_reset();
    cyc(20);
    chk("t5_nreq", 32'(hs_q.size()), 32'd2);
    chk("t5_npop", 32'(pop_q.size()), 32'd2);
    chk("t5_pc1", pop_q[1], 32'h8000_0004);
    chk("t5_fault0", 32'(popf_q[0]), 32'd0);
    chk("t5_fault1", 32'(popf_q[1]), 32'd1);
    chk("t5_halted", 32'(ic_arvalid), 32'd0);
    fault_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(8);
    chk("t5_resume", hs_q[2], 32'h8000_0100);

    // 6: asynchronous reset mid-RESP with one buffered entry
    out_ready = 1'b0;
    do_reset();
    wait_for(2, "t6_out_valid");
    r_block = 1'b1;
    wait_for(1, "t6_rready");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arvalid", 32'(ic_arvalid), 32'd0);
    chk("t6_araddr", ic_araddr, 32'h8000_0000);
    chk("t6_rready", 32'(ic_rready), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_pc", out_pc, 32'd0);
    chk("t6_out_inst", out_inst, 32'd0);
    r_block = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
    cyc(10);
    chk("t6_restart_addr", hs_q[0], 32'h8000_0000);
    chk("t6_restart_pc", pop_q[0], 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
